// File: rtl/ddr_avalon_pkg.sv
// Shared types and defaults for the DDR Avalon request master.
package ddr_avalon_pkg;

  localparam int unsigned DDR_ADDR_W = 25;
  localparam int unsigned DDR_DATA_W = 256;

  // Every transaction is a single beat.
  localparam logic [6:0] AMM_BURST_ONE = 7'd1;

  typedef enum logic [2:0] {
    StIdle,
    StWrCmd,
    StRdCmd,
    StRdWait,
    StDone,
    StRelease
  } state_e;

endpackage

// File: rtl/ddr_avalon_rq_master.sv
// Avalon-MM request master.
// Takes the level-held wr_rq/rd_rq requests from the bridge, issues one single-beat
// Avalon-MM transaction per request, and answers with a one-cycle action_done pulse.
// Optional macro DDR_AVALON_RQ_TIMEOUT_EN adds a read-response timeout with a
// sticky err_timeout flag. Without it, err_timeout is tied low.
module ddr_avalon_rq_master
  import ddr_avalon_pkg::*;
#(
  parameter int unsigned ADDR_W         = DDR_ADDR_W,
  parameter int unsigned DATA_W         = DDR_DATA_W,
  parameter int unsigned BE_W           = DATA_W / 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              avalon_clk,
  input  logic              avalon_reset,
  input  logic              local_cal_success,
  input  logic              wr_rq,
  input  logic              rd_rq,
  input  logic [ADDR_W-1:0] wr_adr,
  input  logic [ADDR_W-1:0] rd_adr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BE_W-1:0]   byte_enable,
  output logic              action_done,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic [ADDR_W-1:0] amm_address,
  output logic              amm_read,
  output logic              amm_write,
  output logic [DATA_W-1:0] amm_writedata,
  output logic [BE_W-1:0]   amm_byteenable,
  output logic [6:0]        amm_burstcount,
  input  logic              amm_waitrequest,
  input  logic [DATA_W-1:0] amm_readdata,
  input  logic              amm_readdatavalid,
  output logic              err_timeout
);

  // A timeout below 2 cycles cannot be represented by the RD_WAIT counter.
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_e state_q;
  logic   timeout_hit;

`ifdef DDR_AVALON_RQ_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] to_cnt_q;

  assign timeout_hit = (to_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign amm_burstcount = AMM_BURST_ONE;
  assign busy           = (state_q != StIdle);

  // Request FSM; all Avalon outputs and completion pulses are registered here.
  always_ff @(posedge avalon_clk) begin
    if (avalon_reset) begin
      state_q        <= StIdle;
      amm_read       <= 1'b0;
      amm_write      <= 1'b0;
      amm_address    <= '0;
      amm_writedata  <= '0;
      amm_byteenable <= '0;
      action_done    <= 1'b0;
      rd_valid       <= 1'b0;
      rd_data        <= '0;
`ifdef DDR_AVALON_RQ_TIMEOUT_EN
      to_cnt_q       <= '0;
      err_timeout    <= 1'b0;
`endif
    end else begin
      action_done <= 1'b0;
      rd_valid    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (local_cal_success) begin
            // Write has priority; a concurrent read is reconsidered only after RELEASE.
            if (wr_rq) begin
              amm_address    <= wr_adr;
              amm_writedata  <= wr_data;
              amm_byteenable <= byte_enable;
              amm_write      <= 1'b1;
              state_q        <= StWrCmd;
            end else if (rd_rq) begin
              amm_address <= rd_adr;
              amm_read    <= 1'b1;
              state_q     <= StRdCmd;
            end
          end
        end
        StWrCmd: begin
          if (!amm_waitrequest) begin
            amm_write   <= 1'b0;
            action_done <= 1'b1;
            state_q     <= StDone;
          end
        end
        StRdCmd: begin
          if (!amm_waitrequest) begin
            amm_read <= 1'b0;
            state_q  <= StRdWait;
`ifdef DDR_AVALON_RQ_TIMEOUT_EN
            to_cnt_q <= '0;
`endif
          end
        end
        StRdWait: begin
          if (amm_readdatavalid) begin
            rd_data     <= amm_readdata;
            action_done <= 1'b1;
            rd_valid    <= 1'b1;
            state_q     <= StDone;
          end else if (timeout_hit) begin
            // rd_data keeps its previous value on a timeout.
            action_done <= 1'b1;
            rd_valid    <= 1'b1;
            state_q     <= StDone;
`ifdef DDR_AVALON_RQ_TIMEOUT_EN
            err_timeout <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
`endif
          end
        end
        StDone: begin
          state_q <= StRelease;
        end
        StRelease: begin
          // Upstream drops its level only after seeing done; wait so it cannot re-trigger.
          if (!wr_rq && !rd_rq) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_avalon_rq_master.sv
// Directed self-checking bench for ddr_avalon_rq_master.
module tb_ddr_avalon_rq_master;

  localparam int unsigned ADDR_W = 25;
  localparam int unsigned DATA_W = 256;
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned TO_CYC = 16;

  logic              avalon_clk = 1'b0;
  logic              avalon_reset;
  logic              local_cal_success;
  logic              wr_rq;
  logic              rd_rq;
  logic [ADDR_W-1:0] wr_adr;
  logic [ADDR_W-1:0] rd_adr;
  logic [DATA_W-1:0] wr_data;
  logic [BE_W-1:0]   byte_enable;
  logic              action_done;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              busy;
  logic [ADDR_W-1:0] amm_address;
  logic              amm_read;
  logic              amm_write;
  logic [DATA_W-1:0] amm_writedata;
  logic [BE_W-1:0]   amm_byteenable;
  logic [6:0]        amm_burstcount;
  logic              amm_waitrequest;
  logic [DATA_W-1:0] amm_readdata;
  logic              amm_readdatavalid;
  logic              err_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  ddr_avalon_rq_master #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .BE_W          (BE_W),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .avalon_clk       (avalon_clk),
    .avalon_reset     (avalon_reset),
    .local_cal_success(local_cal_success),
    .wr_rq            (wr_rq),
    .rd_rq            (rd_rq),
    .wr_adr           (wr_adr),
    .rd_adr           (rd_adr),
    .wr_data          (wr_data),
    .byte_enable      (byte_enable),
    .action_done      (action_done),
    .rd_data          (rd_data),
    .rd_valid         (rd_valid),
    .busy             (busy),
    .amm_address      (amm_address),
    .amm_read         (amm_read),
    .amm_write        (amm_write),
    .amm_writedata    (amm_writedata),
    .amm_byteenable   (amm_byteenable),
    .amm_burstcount   (amm_burstcount),
    .amm_waitrequest  (amm_waitrequest),
    .amm_readdata     (amm_readdata),
    .amm_readdatavalid(amm_readdatavalid),
    .err_timeout      (err_timeout)
  );

  always #5 avalon_clk = ~avalon_clk;

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge avalon_clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [DATA_W-1:0] got,
                          input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int cnt;

  initial begin
    avalon_reset      = 1'b1;
    local_cal_success = 1'b0;
    wr_rq             = 1'b0;
    rd_rq             = 1'b0;
    wr_adr            = '0;
    rd_adr            = '0;
    wr_data           = '0;
    byte_enable       = '0;
    amm_waitrequest   = 1'b0;
    amm_readdata      = '0;
    amm_readdatavalid = 1'b0;
    #1;
    tick();
    tick();
    avalon_reset = 1'b0;

    // Reset state
    check_eq("rst_write", amm_write, 0);
    check_eq("rst_read", amm_read, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", action_done, 0);
    check_eq("rst_rdata", rd_data, 0);
    check_eq("rst_burst", amm_burstcount, 1);
    check_eq("rst_err", err_timeout, 0);

    // 1. Write, zero wait
    local_cal_success = 1'b1;
    wr_adr            = 25'h000123;
    wr_data           = {32{8'hA5}};
    byte_enable       = '1;
    wr_rq             = 1'b1;
    tick();
    check_eq("w_write", amm_write, 1);
    check_eq("w_addr", amm_address, 25'h000123);
    check_eq("w_wdata", amm_writedata, {32{8'hA5}});
    check_eq("w_be", amm_byteenable, {BE_W{1'b1}});
    check_eq("w_done_early", action_done, 0);
    tick();
    check_eq("w_write_off", amm_write, 0);
    check_eq("w_done", action_done, 1);
    check_eq("w_rdvalid", rd_valid, 0);
    tick();
    check_eq("w_done_pulse", action_done, 0);
    check_eq("w_busy_hold", busy, 1);
    tick();
    check_eq("w_busy_hold2", busy, 1);
    check_eq("w_no_retrig", amm_write, 0);
    wr_rq = 1'b0;
    tick();
    check_eq("w_idle", busy, 0);

    // 2. Read with backpressure
    rd_adr          = 25'h1FFFFFF;
    rd_rq           = 1'b1;
    amm_waitrequest = 1'b1;
    cnt             = 0;
    tick();
    check_eq("r_addr", amm_address, 25'h1FFFFFF);
    if (amm_read) cnt++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (amm_read) cnt++;
    end
    amm_waitrequest = 1'b0;
    tick();
    check_eq("r_read_off", amm_read, 0);
    check_eq("r_read_len", cnt, 4);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("r_no_done_wait", action_done, 0);
    end
    amm_readdata      = 256'h1234;
    amm_readdatavalid = 1'b1;
    tick();
    amm_readdatavalid = 1'b0;
    amm_readdata      = '0;
    check_eq("r_done", action_done, 1);
    check_eq("r_valid", rd_valid, 1);
    check_eq("r_data", rd_data, 256'h1234);
    tick();
    check_eq("r_valid_pulse", rd_valid, 0);
    check_eq("r_data_hold", rd_data, 256'h1234);
    rd_rq = 1'b0;
    tick();
    check_eq("r_idle", busy, 0);

    // Stray readdatavalid while idle is ignored
    amm_readdata      = 256'hBEEF;
    amm_readdatavalid = 1'b1;
    tick();
    amm_readdatavalid = 1'b0;
    check_eq("stray_data", rd_data, 256'h1234);
    check_eq("stray_valid", rd_valid, 0);

    // 3. Simultaneous requests: write wins, held rd_rq does not re-trigger
    wr_adr = 25'h55;
    rd_adr = 25'h66;
    wr_rq  = 1'b1;
    rd_rq  = 1'b1;
    tick();
    check_eq("s_write", amm_write, 1);
    check_eq("s_read", amm_read, 0);
    check_eq("s_addr", amm_address, 25'h55);
    tick();
    check_eq("s_done", action_done, 1);
    wr_rq = 1'b0;
    cnt   = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (amm_read || amm_write || !busy) cnt++;
    end
    check_eq("s_held_quiet", cnt, 0);
    rd_rq = 1'b0;
    tick();
    check_eq("s_idle", busy, 0);
    tick();
    check_eq("s_no_read", amm_read, 0);

    // 4. Calibration gating
    local_cal_success = 1'b0;
    wr_adr            = 25'h77;
    wr_rq             = 1'b1;
    cnt               = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (amm_write || busy) cnt++;
    end
    check_eq("c_gated", cnt, 0);
    local_cal_success = 1'b1;
    tick();
    check_eq("c_write", amm_write, 1);
    check_eq("c_addr", amm_address, 25'h77);
    tick();
    check_eq("c_done", action_done, 1);
    wr_rq = 1'b0;
    tick();
    tick();
    check_eq("c_idle", busy, 0);

    // 5. Reset during RD_CMD and RD_WAIT
    rd_adr          = 25'h99;
    rd_rq           = 1'b1;
    amm_waitrequest = 1'b1;
    tick();
    check_eq("x_read", amm_read, 1);
    avalon_reset = 1'b1;
    rd_rq        = 1'b0;
    tick();
    check_eq("x_read_drop", amm_read, 0);
    check_eq("x_addr_rst", amm_address, 0);
    avalon_reset    = 1'b0;
    amm_waitrequest = 1'b0;
    rd_rq           = 1'b1;
    tick();
    tick();
    check_eq("x_wait_busy", busy, 1);
    avalon_reset = 1'b1;
    rd_rq        = 1'b0;
    tick();
    avalon_reset = 1'b0;
    check_eq("x_busy", busy, 0);
    check_eq("x_rdata", rd_data, 0);
    check_eq("x_done", action_done, 0);
    amm_readdata      = 256'hCAFE;
    amm_readdatavalid = 1'b1;
    tick();
    amm_readdatavalid = 1'b0;
    check_eq("x_stale_data", rd_data, 0);
    check_eq("x_stale_valid", rd_valid, 0);
    check_eq("x_stale_done", action_done, 0);

    // 6. Read-response timeout
    rd_adr = 25'h42;
    rd_rq  = 1'b1;
    tick();
    tick();
    cnt = 0;
`ifdef DDR_AVALON_RQ_TIMEOUT_EN
    for (int i = 0; i < 40; i++) begin
      tick();
      cnt++;
      if (action_done) break;
    end
    check_eq("t_latency", cnt, TO_CYC);
    check_eq("t_done", action_done, 1);
    check_eq("t_valid", rd_valid, 1);
    check_eq("t_data", rd_data, 0);
    check_eq("t_err", err_timeout, 1);
    rd_rq = 1'b0;
    tick();
    tick();
    check_eq("t_idle", busy, 0);
    check_eq("t_err_sticky", err_timeout, 1);
`else
    for (int i = 0; i < 40; i++) begin
      tick();
      if (action_done) cnt++;
    end
    check_eq("t_no_timeout", cnt, 0);
    check_eq("t_still_busy", busy, 1);
    check_eq("t_err_tied", err_timeout, 0);
    avalon_reset = 1'b1;
    rd_rq        = 1'b0;
    tick();
    avalon_reset = 1'b0;
    check_eq("t_idle", busy, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
